// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer:
// controller states, ALU opcodes and flag layout.
package div_sequencer_pkg;

  localparam int CF_IDX      = 0;
  localparam int ALU_OP_BITS = 4;

  localparam logic [15:0] FLAGS_IN = 16'h0002;

  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_OP_SELA = 4'h0,
    ALU_OP_SUB  = 4'h3
  } alu_op_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_CHECK,
    DS_ITER,
    DS_DONE
  } divseq_state_t;

  function automatic logic [15:0] byte_mask(
    input logic is8
  );
    return is8 ? 16'h00FF : 16'hFFFF;
  endfunction

endpackage

// File: rtl/div_sequencer.sv
// Restoring unsigned divider controller for DIV r/m8 and r/m16.
// One quotient bit per clock, subtraction done by the shared ALU.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_8_bit,
  input  logic [WIDTH-1:0] dividend_hi,
  input  logic [WIDTH-1:0] dividend_lo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divide_error,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output alu_op_t          alu_op,
  output logic             alu_is_8_bit,
  output logic [WIDTH-1:0] alu_flags_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_flags_out
);

  divseq_state_t    state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             mode8;
  logic [3:0]       count;

  logic [WIDTH-1:0] mask;
  logic             hi;
  logic             q_top;
  logic             cf;
  logic             accept;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_flags;

  assign unused_flags = ^alu_flags_out[WIDTH-1:1];

  assign mask   = byte_mask(mode8);
  assign hi     = mode8 ? r[7] : r[WIDTH-1];
  assign q_top  = mode8 ? q[7] : q[WIDTH-1];
  assign cf     = alu_flags_out[CF_IDX];
  assign accept = hi | ~cf;
  assign shl    = {r[WIDTH-2:0], q_top} & mask;
  assign r_next = (accept ? alu_out : shl) & mask;
  assign q_next = {q[WIDTH-2:0], accept} & mask;

  assign alu_op       = busy ? ALU_OP_SUB : ALU_OP_SELA;
  assign alu_is_8_bit = mode8;
  assign alu_flags_in = FLAGS_IN;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    unique case (state)
      DS_CHECK: begin
        alu_a = r;
        alu_b = dvs;
      end
      DS_ITER: begin
        alu_a = shl;
        alu_b = dvs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DS_IDLE;
      r            <= '0;
      q            <= '0;
      dvs          <= '0;
      mode8        <= 1'b0;
      count        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      divide_error <= 1'b0;
    end else begin
      unique case (state)
        DS_IDLE: begin
          if (start) begin
            mode8 <= is_8_bit;
            r     <= dividend_hi & byte_mask(is_8_bit);
            q     <= dividend_lo & byte_mask(is_8_bit);
            dvs   <= divisor & byte_mask(is_8_bit);
            busy  <= 1'b1;
            state <= DS_CHECK;
          end
        end
        DS_CHECK: begin
          // No borrow means R >= divisor: zero divisor or overflow
          if (!cf) begin
            divide_error <= 1'b1;
            done         <= 1'b1;
            state        <= DS_DONE;
          end else begin
            count <= mode8 ? 4'd7 : 4'd15;
            state <= DS_ITER;
          end
        end
        DS_ITER: begin
          r <= r_next;
          q <= q_next;
          if (count == 4'd0) begin
            divide_error <= 1'b0;
            done         <= 1'b1;
            quotient     <= q_next;
            remainder    <= r_next;
            state        <= DS_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DS_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= DS_IDLE;
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural ALU, arithmetic
// reference model and a done-driven scoreboard.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_8_bit = 1'b0;
  logic [15:0] dividend_hi = '0;
  logic [15:0] dividend_lo = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        divide_error;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  alu_op_t     alu_op;
  logic        alu_is_8_bit;
  logic [15:0] alu_flags_in;
  logic [15:0] alu_out;
  logic [15:0] alu_flags_out;

  div_sequencer #(.WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_8_bit(is_8_bit),
    .dividend_hi(dividend_hi),
    .dividend_lo(dividend_lo),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .divide_error(divide_error),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_is_8_bit(alu_is_8_bit),
    .alu_flags_in(alu_flags_in),
    .alu_out(alu_out),
    .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  // ALU: SUB sets CF on borrow at the selected width
  always_comb begin
    logic [16:0] d17;
    logic [8:0]  d9;
    alu_out       = alu_a;
    alu_flags_out = alu_flags_in;
    d17 = {1'b0, alu_a} - {1'b0, alu_b};
    d9  = {1'b0, alu_a[7:0]} - {1'b0, alu_b[7:0]};
    if (alu_op == ALU_OP_SUB) begin
      if (alu_is_8_bit) begin
        alu_out          = {alu_a[15:8], d9[7:0]};
        alu_flags_out[0] = d9[8];
      end else begin
        alu_out          = d17[15:0];
        alu_flags_out[0] = d17[16];
      end
    end else begin
      alu_flags_out[0] = 1'b0;
    end
  end

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          lat;
    int          t;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] prev_q = '0;
  logic [15:0] prev_r = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t model(
    input logic is8, input logic [15:0] hi,
    input logic [15:0] lo, input logic [15:0] dv
  );
    exp_t        e;
    logic [31:0] dd;
    logic [31:0] d;
    logic [31:0] lim;
    dd  = is8 ? {16'h0, hi[7:0], lo[7:0]} : {hi, lo};
    d   = is8 ? {24'h0, dv[7:0]} : {16'h0, dv};
    lim = is8 ? 32'd256 : 32'd65536;
    e.t = cyc;
    if (d == 0 || dd / d >= lim) begin
      e.err = 1'b1;
      e.q   = prev_q;
      e.r   = prev_r;
      e.lat = 2;
    end else begin
      e.err = 1'b0;
      e.q   = 16'(dd / d);
      e.r   = 16'(dd % d);
      e.lat = is8 ? 10 : 18;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("divide_error", divide_error, e.err);
        chk("latency", cyc - e.t, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic issue(
    input logic is8, input logic [15:0] hi,
    input logic [15:0] lo, input logic [15:0] dv,
    input bit push
  );
    exp_t e;
    wait_idle();
    is_8_bit    = is8;
    dividend_hi = hi;
    dividend_lo = lo;
    divisor     = dv;
    start       = 1'b1;
    if (push) begin
      e = model(is8, hi, lo, dv);
      sb.push_back(e);
      if (!e.err) begin
        prev_q = e.q;
        prev_r = e.r;
      end
    end
    @(negedge clk);
    start       = 1'b0;
    is_8_bit    = ~is8;
    dividend_hi = 16'($urandom);
    dividend_lo = 16'($urandom);
    divisor     = 16'($urandom);
  endtask

  task automatic run(
    input logic is8, input logic [15:0] hi,
    input logic [15:0] lo, input logic [15:0] dv
  );
    issue(is8, hi, lo, dv, 1'b1);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", divide_error, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, ALU_OP_SELA);

    run(1'b0, 16'h0001, 16'h2345, 16'h0100);
    run(1'b1, 16'h0000, 16'h0064, 16'h0007);
    run(1'b0, 16'h1234, 16'h5678, 16'h0000);
    run(1'b1, 16'h0000, 16'h0033, 16'h0000);
    run(1'b0, 16'h0100, 16'h0000, 16'h0100);
    run(1'b1, 16'h0005, 16'h0000, 16'h0005);
    run(1'b0, 16'hFFFE, 16'hFFFF, 16'hFFFF);
    run(1'b1, 16'h00FE, 16'h00FF, 16'h00FF);

    // Busy check and ignored start while iterating
    issue(1'b0, 16'h0012, 16'h3456, 16'h0789, 1'b1);
    chk("busy_check", busy, 1);
    repeat (4) @(negedge clk);
    chk("busy_iter", busy, 1);
    is_8_bit    = 1'b1;
    dividend_hi = 16'h0000;
    dividend_lo = 16'h0011;
    divisor     = 16'h0003;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset in the middle of the loop aborts without a done pulse
    issue(1'b0, 16'h0003, 16'h0000, 16'h0007, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset  = 1'b0;
    prev_q = '0;
    prev_r = '0;
    repeat (25) @(negedge clk);
    run(1'b0, 16'h0000, 16'h0000, 16'h0000);
    run(1'b0, 16'h0003, 16'h0000, 16'h0007);

    for (int i = 0; i < 60; i++) begin
      logic        is8;
      logic [15:0] dv;
      logic [15:0] hi;
      logic [15:0] lo;
      is8 = 1'($urandom);
      dv  = is8 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 9) == 0) dv = '0;
      lo = is8 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (dv != 0 && $urandom_range(0, 4) != 0)
        hi = 16'($urandom % dv);
      else
        hi = is8 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      run(is8, hi, lo, dv);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
